// File: rtl/mem_arbiter.sv
// Two-requester memory-port arbiter: the data path (D) has fixed priority, and a starvation counter forces the instruction path (I) through.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
`ifdef MEM_ARB_STATS_EN
   input  logic              stat_clr,
   output logic [31:0]       igrant_cnt,
   output logic [31:0]       dgrant_cnt,
   output logic [31:0]       istall_cnt,
`endif
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [ADDR_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic [ADDR_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic              ram_ready
);

   typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_e;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   state_e            state_q, state_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] store_q, store_d;
   logic [7:0]        starve_q, starve_d;
   logic              d_req;
   logic              enter_i, enter_d;

   assign d_req = dREN | dWEN;

   // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      ren_d   = ren_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      store_d = store_q;
      unique case (state_q)
         IDLE: begin
            if (d_req && (starve_q < STARVE_LIM)) begin
               state_d = DGRANT;
               wen_d   = dWEN;
               ren_d   = dREN & ~dWEN;
               addr_d  = daddr;
               store_d = dstore;
            end else if (iREN) begin
               state_d = IGRANT;
               ren_d   = 1'b1;
               wen_d   = 1'b0;
               addr_d  = iaddr;
               store_d = '0;
            end
         end
         DGRANT, IGRANT: begin
            if (ram_ready) begin
               state_d = IDLE;
               ren_d   = 1'b0;
               wen_d   = 1'b0;
               addr_d  = '0;
               store_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_i = (state_q == IDLE) && (state_d == IGRANT);
   assign enter_d = (state_q == IDLE) && (state_d == DGRANT);

   // Clearing on the IGRANT entry edge takes priority over that cycle's increment.
   always_comb begin
      starve_d = starve_q;
      if (enter_i)
         starve_d = '0;
      else if (iREN && (state_q != IGRANT) && (starve_q != STARVE_LIM))
         starve_d = starve_q + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         starve_q <= starve_d;
      end
   end

   assign ramREN   = ren_q;
   assign ramWEN   = wen_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;

   assign dwait = ~((state_q == DGRANT) && ram_ready);
   assign iwait = ~((state_q == IGRANT) && ram_ready);
   assign dload = ramload;
   assign iload = ramload;

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         igrant_cnt <= '0;
         dgrant_cnt <= '0;
         istall_cnt <= '0;
      end else if (stat_clr) begin
         igrant_cnt <= '0;
         dgrant_cnt <= '0;
         istall_cnt <= '0;
      end else begin
         if (enter_i && (igrant_cnt != '1)) igrant_cnt <= igrant_cnt + 32'd1;
         if (enter_d && (dgrant_cnt != '1)) dgrant_cnt <= dgrant_cnt + 32'd1;
         if (iREN && iwait && (istall_cnt != '1)) istall_cnt <= istall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences for starvation, reset abort and stats.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN, ram_ready;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;
`ifdef MEM_ARB_STATS_EN
   logic        stat_clr;
   logic [31:0] igrant_cnt, dgrant_cnt, istall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
`ifdef MEM_ARB_STATS_EN
      .stat_clr(stat_clr), .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt), .istall_cnt(istall_cnt),
`endif
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready)
   );

   typedef struct {
      logic        iren;
      logic [31:0] iaddr;
      logic        dren;
      logic        dwen;
      logic [31:0] daddr;
      logic [31:0] dstore;
      logic        rdy;
      logic [31:0] rload;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic        e_iwait;
      logic        e_dwait;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
                      input logic [31:0] da, input logic [31:0] ds, input logic rdy, input logic [31:0] rl,
                      input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                      input logic [31:0] e_store, input logic e_iwait, input logic e_dwait);
      vec_t v;
      v.iren = iren; v.iaddr = ia; v.dren = dren; v.dwen = dwen; v.daddr = da; v.dstore = ds;
      v.rdy = rdy; v.rload = rl; v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
      v.e_store = e_store; v.e_iwait = e_iwait; v.e_dwait = e_dwait;
      vq.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic run_txn(input bit is_d);
      if (is_d) dREN = 1'b1; else iREN = 1'b1;
      next_cycle();
      dREN = 1'b0; iREN = 1'b0; ram_ready = 1'b1;
      next_cycle();
      ram_ready = 1'b0;
   endtask
`endif

   initial begin
      int dcnt;
      int rounds;
      nRST = 1'b0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
`ifdef MEM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif

      //   iren iaddr dren dwen daddr dstore rdy rload | ren wen addr store iwait dwait
      add(1, 32'h40, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 1, 1);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0,                      1, 0, 32'h40, 0, 1, 1);
      add(1, 32'h40, 0, 0, 0, 0, 0, 0,                      1, 0, 32'h40, 0, 1, 1);
      add(1, 32'h40, 0, 0, 0, 0, 1, 32'h2108FFFF,           1, 0, 32'h40, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 1, 1);
      add(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, 0, 0,      0, 0, 0, 0, 1, 1);
      add(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, 1, 0,      0, 1, 32'h80, 32'hDEADBEEF, 1, 0);
      add(1, 32'h44, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 1, 1);
      add(1, 32'h44, 0, 0, 0, 0, 1, 32'h12345678,           1, 0, 32'h44, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 1, 32'hC0, 32'h55AA55AA, 0, 0,           0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0,                           0, 1, 32'hC0, 32'h55AA55AA, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0,                           0, 1, 32'hC0, 32'h55AA55AA, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 32'h100, 0, 0, 0,                     0, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,                1, 0, 32'h100, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D,                0, 0, 0, 0, 1, 1);

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset ramREN", {31'b0, ramREN}, 32'd0);
      check("reset ramWEN", {31'b0, ramWEN}, 32'd0);
      check("reset ramaddr", ramaddr, 32'd0);
      check("reset ramstore", ramstore, 32'd0);
      check("reset iwait", {31'b0, iwait}, 32'd1);
      check("reset dwait", {31'b0, dwait}, 32'd1);
      nRST = 1'b1;
      next_cycle();

      // Per-cycle vector table
      for (int k = 0; k < vq.size(); k++) begin
         iREN = vq[k].iren; iaddr = vq[k].iaddr; dREN = vq[k].dren; dWEN = vq[k].dwen;
         daddr = vq[k].daddr; dstore = vq[k].dstore; ram_ready = vq[k].rdy; ramload = vq[k].rload;
         @(negedge CLK);
         check($sformatf("row%0d ramREN", k), {31'b0, ramREN}, {31'b0, vq[k].e_ren});
         check($sformatf("row%0d ramWEN", k), {31'b0, ramWEN}, {31'b0, vq[k].e_wen});
         check($sformatf("row%0d iwait", k), {31'b0, iwait}, {31'b0, vq[k].e_iwait});
         check($sformatf("row%0d dwait", k), {31'b0, dwait}, {31'b0, vq[k].e_dwait});
         if (vq[k].e_ren || vq[k].e_wen) begin
            check($sformatf("row%0d ramaddr", k), ramaddr, vq[k].e_addr);
            check($sformatf("row%0d ramstore", k), ramstore, vq[k].e_store);
         end
         if (!vq[k].e_iwait) check($sformatf("row%0d iload", k), iload, vq[k].rload);
         if (!vq[k].e_dwait) check($sformatf("row%0d dload", k), dload, vq[k].rload);
         next_cycle();
      end

      // Starvation: I held, D always requesting, memory always ready -> D, D, I per round
      iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h300;
      ram_ready = 1'b1; ramload = 32'h0;
      dcnt = 0;
      rounds = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (!dwait) dcnt++;
         if (!iwait) begin
            check($sformatf("starve round%0d D grants before I", rounds), dcnt, 32'd2);
            dcnt = 0;
            rounds++;
            if (rounds == 2) break;
         end
         next_cycle();
      end
      check("starve I grants within bound", rounds, 32'd2);
      next_cycle();
      iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
      next_cycle();

      // Reset pulsed mid-DGRANT, then a pending I read is granted from IDLE
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'h11112222;
      next_cycle();
      dREN = 1'b0; dWEN = 1'b0;
      check("pre-abort ramWEN", {31'b0, ramWEN}, 32'd1);
      ram_ready = 1'b1;
      #1 nRST = 1'b0;
      #1;
      check("abort ramREN", {31'b0, ramREN}, 32'd0);
      check("abort ramWEN", {31'b0, ramWEN}, 32'd0);
      check("abort ramaddr", ramaddr, 32'd0);
      check("abort dwait", {31'b0, dwait}, 32'd1);
      check("abort iwait", {31'b0, iwait}, 32'd1);
      iREN = 1'b1; iaddr = 32'h500; ram_ready = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      next_cycle();
      check("post-reset I grant ramREN", {31'b0, ramREN}, 32'd1);
      check("post-reset I grant ramaddr", ramaddr, 32'h500);
      ram_ready = 1'b1; ramload = 32'h600DCAFE;
      @(negedge CLK);
      check("post-reset iwait", {31'b0, iwait}, 32'd0);
      check("post-reset iload", iload, 32'h600DCAFE);
      next_cycle();
      iREN = 1'b0; ram_ready = 1'b0;
      next_cycle();

`ifdef MEM_ARB_STATS_EN
      stat_clr = 1'b1;
      next_cycle();
      stat_clr = 1'b0;
      run_txn(1'b0); next_cycle();
      run_txn(1'b1); next_cycle();
      run_txn(1'b0); next_cycle();
      run_txn(1'b1); next_cycle();
      run_txn(1'b0); next_cycle();
      @(negedge CLK);
      check("stats igrant_cnt", igrant_cnt, 32'd3);
      check("stats dgrant_cnt", dgrant_cnt, 32'd2);
      check("stats istall_cnt", istall_cnt, 32'd3);
      next_cycle();
      stat_clr = 1'b1;
      next_cycle();
      stat_clr = 1'b0;
      @(negedge CLK);
      check("clr igrant_cnt", igrant_cnt, 32'd0);
      check("clr dgrant_cnt", dgrant_cnt, 32'd0);
      check("clr istall_cnt", istall_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single memory port between the instruction-fetch path (I) and the data path (D) of the pipelined CPU.
- Latches the winning request, holds the memory command stable until the memory signals ready, then returns the read data and a one-cycle completion (wait low) to that requester only.
- D has fixed priority; a starvation counter guarantees forward progress for I.

Parameters:
- ADDR_W, 32, width of addresses and data words.
- STARVE_MAX, 4, cycles I may be pending and denied before it is forced to win the next arbitration; legal range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iload  out  ADDR_W  instruction read data.
- iwait  out  1  low for exactly the completion cycle of an I transaction.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  data write value.
- dload  out  ADDR_W  data read data.
- dwait  out  1  low for exactly the completion cycle of a D transaction.
- ramREN  out  1  memory read strobe.
- ramWEN  out  1  memory write strobe.
- ramaddr  out  ADDR_W  memory address.
- ramstore  out  ADDR_W  memory write value.
- ramload  in  ADDR_W  memory read data.
- ram_ready  in  1  memory has completed the current command this cycle.

Behaviour:
- Reset values (asynchronous on nRST low, including mid-transaction): state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, starve counter=0. An aborted memory command is simply dropped.
- States: IDLE, DGRANT, IGRANT.
- IDLE arbitration at the rising edge:
  - D request = dREN|dWEN.
  - If D request and starve<STARVE_MAX, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- On a grant, latch address, store data and write flag into command registers. Requests are not re-sampled while in a GRANT state.
- DGRANT: ramWEN=latched dWEN, ramREN=latched dREN&~dWEN (dWEN wins if both set), ramaddr/ramstore from latches.
- IGRANT: ramREN=1, ramWEN=0, ramaddr=latched iaddr, ramstore=0.
- Command signals are registered and stable for the whole grant. They drop to 0 in the cycle after completion.
- Completion is the cycle in a GRANT state with ram_ready=1:
  - dwait (DGRANT) or iwait (IGRANT) is low combinationally. dload/iload = ramload in that cycle.
  - Next state is IDLE. Minimum transaction is 2 cycles (grant edge plus ready cycle), with one IDLE cycle between back-to-back transactions.
- iload and dload are only valid while the matching wait is low; otherwise their value is don't-care.
- If a requester drops its request mid-grant, the transaction still completes and the wait still pulses.
- Starve counter:
  - Increments (saturating at STARVE_MAX) in every cycle where iREN=1 and state≠IGRANT.
  - Clears on entry to IGRANT.
  - When starve==STARVE_MAX and both request, I wins.
- ram_ready while in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs igrant_cnt and dgrant_cnt (32-bit each; increment on entry to IGRANT/DGRANT) and istall_cnt (32-bit; increments each cycle iREN=1 and iwait=1).
  - All three counters saturate at all-ones and reset to 0.
  - A synchronous input stat_clr (1 bit) clears them, with priority over increment.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical either way.

Test Plan:
- I read only: iREN=1, iaddr=0x40, ram_ready asserted 3 cycles after grant with ramload=0x2108FFFF -> ramREN=1 and ramaddr=0x40 for 3 cycles; iwait low 1 cycle with iload=0x2108FFFF; dwait stays 1.
- Simultaneous request: iREN=1, dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ram_ready 1 cycle after each grant -> D write served first (ramWEN=1, ramstore=0xDEADBEEF), then IDLE, then I read; iwait stays 1 until the I completion.
- Starvation: STARVE_MAX=4, iREN held, dREN re-asserted in every IDLE -> I granted at the latest in the first arbitration after the counter reaches 4; starve counter returns to 0.
- dREN=1 and dWEN=1 together -> ramWEN=1, ramREN=0.
- nRST pulsed low mid-DGRANT -> all ram strobes 0 and both waits 1 immediately; after release, a pending iREN is granted from IDLE.
- With MEM_ARB_STATS_EN: 3 I and 2 D transactions -> igrant_cnt=3, dgrant_cnt=2; stat_clr for one cycle -> all counters 0.
